key_jk_ctrl: RTL and testbench

KEY_JK_CTRL -- requirements
Module: key_jk_ctrl

---
 rtl/key_pkg.sv | 19 +
 rtl/key_chan.sv | 87 ++++++++
 rtl/key_jk_ctrl.sv | 44 ++++
 tb/tb_key_jk_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and helpers for the J/K key front-end.
// Default debounce and repeat timings assume a 12 MHz system clock.
package key_pkg;

    localparam int unsigned CNT_MAX_DEF    = 240000;
    localparam int unsigned REPEAT_DLY_DEF = 6000000;
    localparam int unsigned REPEAT_PER_DEF = 1200000;

    // The raw board keys are active-low, so "released" is the idle level 1.
    typedef enum logic {
        KEY_PRESSED  = 1'b0,
        KEY_RELEASED = 1'b1
    } key_state_e;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: 2-flop synchronizer, debounce counter, press pulse and
// optional auto-repeat (enabled by defining KEY_REPEAT_EN).
module key_chan
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
    parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
    parameter int unsigned REPEAT_PER = REPEAT_PER_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pulse,
    output logic level
);

    localparam int unsigned CNT_W = cnt_width(CNT_MAX);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    key_state_e          stable_q, stable_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pulse_q, pulse_d;

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_W = cnt_width(REPEAT_DLY);
    logic [REP_W-1:0]    rep_q, rep_d;
`endif

    // The repeat reload value is REPEAT_DLY-REPEAT_PER, so it must not underflow.
    if (REPEAT_DLY < REPEAT_PER) begin : g_repeat_cfg_invalid
    end

    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (key_state_e'(sync2_q) != stable_q) begin
            if (cnt_q == CNT_W'(CNT_MAX - 1)) begin
                stable_d = key_state_e'(sync2_q);
                pulse_d  = (key_state_e'(sync2_q) == KEY_PRESSED);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`ifdef KEY_REPEAT_EN
        // Reloading to DLY-PER after each repeat makes later pulses REPEAT_PER apart.
        rep_d = '0;
        if (stable_q == KEY_PRESSED && stable_d == KEY_PRESSED) begin
            if (rep_q == REP_W'(REPEAT_DLY - 1)) begin
                pulse_d = 1'b1;
                rep_d   = REP_W'(REPEAT_DLY - REPEAT_PER);
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= KEY_RELEASED;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q    <= '0;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
`ifdef KEY_REPEAT_EN
            rep_q    <= rep_d;
`endif
        end
    end

    assign pulse = pulse_q;
    assign level = (stable_q == KEY_PRESSED);

endmodule

// File: rtl/key_jk_ctrl.sv
// Debounced J/K key controller producing one-cycle pulses for a jk_ff.
// Auto-repeat on held keys is compiled in only when KEY_REPEAT_EN is defined.
module key_jk_ctrl
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
    parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
    parameter int unsigned REPEAT_PER = REPEAT_PER_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic key_j,
    input  logic key_k,
    output logic j,
    output logic k,
    output logic j_lvl,
    output logic k_lvl
);

    key_chan #(
        .CNT_MAX    (CNT_MAX),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_chan_j (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_j),
        .pulse (j),
        .level (j_lvl)
    );

    key_chan #(
        .CNT_MAX    (CNT_MAX),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_chan_k (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_k),
        .pulse (k),
        .level (k_lvl)
    );

endmodule

// File: tb/tb_key_jk_ctrl.sv
// Scoreboard bench for key_jk_ctrl with CNT_MAX=4, REPEAT_DLY=20, REPEAT_PER=8.
module tb_key_jk_ctrl;

    localparam int unsigned CNT_MAX    = 4;
    localparam int unsigned REPEAT_DLY = 20;
    localparam int unsigned REPEAT_PER = 8;
    // Drive at a negedge; the next edge samples it, and the 6th edge (counting that one) qualifies it.
    localparam int QUAL_LAT = 6;

    typedef struct {
        int   cyc;
        logic j;
        logic k;
    } pulse_ev_t;

    typedef struct {
        int   cyc;
        logic val;
    } lvl_ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_j = 1'b1;
    logic key_k = 1'b1;
    logic j, k, j_lvl, k_lvl;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;
    logic prev_jl = 1'b0;
    logic prev_kl = 1'b0;

    pulse_ev_t pulse_exp[$];
    lvl_ev_t   jl_exp[$];
    lvl_ev_t   kl_exp[$];

    key_jk_ctrl #(
        .CNT_MAX    (CNT_MAX),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .key_j (key_j),
        .key_k (key_k),
        .j     (j),
        .k     (k),
        .j_lvl (j_lvl),
        .k_lvl (k_lvl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cyc=%0d got=%b want=%b", name, cyc, actual, expected);
        end
    endtask

    // Drive new key levels now and queue the hand-computed responses.
    task automatic applyStimulus(input logic new_j, input logic new_k,
                                 input logic exp_pj, input logic exp_pk,
                                 input logic jl_chg, input logic kl_chg);
        pulse_ev_t pe;
        lvl_ev_t   le;
        key_j = new_j;
        key_k = new_k;
        if (exp_pj || exp_pk) begin
            pe.cyc = cyc + QUAL_LAT; pe.j = exp_pj; pe.k = exp_pk;
            pulse_exp.push_back(pe);
        end
        if (jl_chg) begin
            le.cyc = cyc + QUAL_LAT; le.val = ~new_j;
            jl_exp.push_back(le);
        end
        if (kl_chg) begin
            le.cyc = cyc + QUAL_LAT; le.val = ~new_k;
            kl_exp.push_back(le);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a pulse or a level change.
    always @(negedge clk) begin
        pulse_ev_t pe;
        lvl_ev_t   le;
        if (mon_en) begin
            while (pulse_exp.size() > 0 && pulse_exp[0].cyc < cyc) begin
                pe = pulse_exp.pop_front();
                checks++; failures++;
                $display("[TB] FAIL pulse_missing got=none want j=%b k=%b at cyc=%0d", pe.j, pe.k, pe.cyc);
            end
            if (j !== 1'b0 || k !== 1'b0) begin
                checks++;
                if (pulse_exp.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL pulse_unexpected cyc=%0d got j=%b k=%b want none", cyc, j, k);
                end else begin
                    pe = pulse_exp.pop_front();
                    if (pe.cyc != cyc || pe.j !== j || pe.k !== k) begin
                        failures++;
                        $display("[TB] FAIL pulse got j=%b k=%b at cyc=%0d want j=%b k=%b at cyc=%0d",
                                 j, k, cyc, pe.j, pe.k, pe.cyc);
                    end
                end
            end
            if (j_lvl !== prev_jl) begin
                checks++;
                if (jl_exp.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL j_lvl_unexpected cyc=%0d got=%b want=%b", cyc, j_lvl, prev_jl);
                end else begin
                    le = jl_exp.pop_front();
                    if (le.cyc != cyc || le.val !== j_lvl) begin
                        failures++;
                        $display("[TB] FAIL j_lvl got=%b at cyc=%0d want=%b at cyc=%0d", j_lvl, cyc, le.val, le.cyc);
                    end
                end
            end
            if (k_lvl !== prev_kl) begin
                checks++;
                if (kl_exp.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL k_lvl_unexpected cyc=%0d got=%b want=%b", cyc, k_lvl, prev_kl);
                end else begin
                    le = kl_exp.pop_front();
                    if (le.cyc != cyc || le.val !== k_lvl) begin
                        failures++;
                        $display("[TB] FAIL k_lvl got=%b at cyc=%0d want=%b at cyc=%0d", k_lvl, cyc, le.val, le.cyc);
                    end
                end
            end
            prev_jl = j_lvl;
            prev_kl = k_lvl;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        lvl_ev_t le;
        int      p;

        waitCycles(3);
        checkOutput("reset_j", j, 1'b0);
        checkOutput("reset_k", k, 1'b0);
        checkOutput("reset_j_lvl", j_lvl, 1'b0);
        checkOutput("reset_k_lvl", k_lvl, 1'b0);
        rst    = 1'b1;
        mon_en = 1'b1;
        waitCycles(4);

        // Clean J press then release.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        waitCycles(12);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        waitCycles(12);

        // Two 3-cycle glitches must not qualify.
        for (int g = 0; g < 2; g++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            waitCycles(3);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            waitCycles(8);
        end
        checkOutput("glitch_j_lvl", j_lvl, 1'b0);

        // Simultaneous press gives a toggle request.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        waitCycles(12);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        waitCycles(12);

        // K alone.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        waitCycles(12);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        waitCycles(12);

        // Reset during a held J press; the key must re-qualify from zero.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        waitCycles(12);
        rst = 1'b0;
        le.cyc = cyc + 1; le.val = 1'b0;
        jl_exp.push_back(le);
        waitCycles(1);
        checkOutput("midrst_j_lvl", j_lvl, 1'b0);
        waitCycles(1);
        checkOutput("midrst_j", j, 1'b0);
        checkOutput("midrst_k_lvl", k_lvl, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        waitCycles(12);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        waitCycles(12);

`ifdef KEY_REPEAT_EN
        // Held press: repeats at +20, then every 8 cycles, none after release.
        p = cyc + QUAL_LAT;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            pulse_ev_t pe;
            pe.cyc = p + REPEAT_DLY + r * REPEAT_PER; pe.j = 1'b1; pe.k = 1'b0;
            pulse_exp.push_back(pe);
        end
        waitCycles(56);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        waitCycles(30);
`else
        p = 0;
        waitCycles(2 + p);
`endif

        waitCycles(4);
        while (pulse_exp.size() > 0) begin
            pulse_ev_t pe;
            pe = pulse_exp.pop_front();
            checks++; failures++;
            $display("[TB] FAIL pulse_missing got=none want j=%b k=%b at cyc=%0d", pe.j, pe.k, pe.cyc);
        end
        while (jl_exp.size() > 0) begin
            le = jl_exp.pop_front();
            checks++; failures++;
            $display("[TB] FAIL j_lvl_missing got=none want=%b at cyc=%0d", le.val, le.cyc);
        end
        while (kl_exp.size() > 0) begin
            le = kl_exp.pop_front();
            checks++; failures++;
            $display("[TB] FAIL k_lvl_missing got=none want=%b at cyc=%0d", le.val, le.cyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
